// File: rtl/magnitude_search_if.sv
// Comparator-side bundle for magnitude_search: start/flags in, trial value and status out.
// The optional `steps` signal exists only when SEARCH_STEP_COUNT_EN is defined.
interface magnitude_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;
`ifdef SEARCH_STEP_COUNT_EN
  logic [$clog2(WIDTH+2)-1:0] steps;
`endif

  modport master (
    input  start, cmp_gt, cmp_eq, cmp_lt,
    output guess, busy, done, found, err, result
`ifdef SEARCH_STEP_COUNT_EN
    , output steps
`endif
  );

  modport slave (
    output start, cmp_gt, cmp_eq, cmp_lt,
    input  guess, busy, done, found, err, result
`ifdef SEARCH_STEP_COUNT_EN
    , input steps
`endif
  );
endinterface

// File: rtl/magnitude_search.sv
// Binary-search controller driving the y side of a magnitude comparator, one probe per clock.
// Define SEARCH_STEP_COUNT_EN to add the `steps` probe counter output.
module magnitude_search #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  magnitude_search_if.master  bus
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  state_t           state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             flags_ok;
  logic             probe_end;
  logic [WIDTH-1:0] guess_up;
  logic [WIDTH-1:0] guess_dn;

  // Sum is one bit wider so lo+hi cannot wrap at the top of the range.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  always_comb begin
    flags_ok  = $onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});
    guess_up  = bus.guess + 1'b1;
    guess_dn  = bus.guess - 1'b1;
    // guess==lo on a "lower" answer also covers the guess==0 underflow case
    probe_end = !flags_ok || bus.cmp_eq ||
                (bus.cmp_gt && (bus.guess == hi)) ||
                (bus.cmp_lt && (bus.guess == lo));
  end

`ifdef SEARCH_STEP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.steps <= '0;
    end else if (state == IDLE && bus.start) begin
      bus.steps <= '0;
    end else if (state == PROBE) begin
      bus.steps <= bus.steps + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lo         <= '0;
      hi         <= '0;
      bus.guess  <= '0;
      bus.result <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.found  <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            lo        <= '0;
            hi        <= MAX_VAL;
            bus.guess <= midpoint('0, MAX_VAL);
            bus.found <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= PROBE;
          end
        end
        PROBE: begin
          if (probe_end) begin
            bus.err   <= !flags_ok;
            bus.found <= flags_ok && bus.cmp_eq;
            if (flags_ok && bus.cmp_eq) begin
              bus.result <= bus.guess;
            end
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (bus.cmp_gt) begin
            lo        <= guess_up;
            bus.guess <= midpoint(guess_up, hi);
          end else begin
            hi        <= guess_dn;
            bus.guess <= midpoint(lo, guess_dn);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
